// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential radix-2 divider.
// Signed support in the divider is enabled by defining DIV_SIGNED_EN.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH = 32;
  localparam int MAG_W     = 64;

  // Callers zero-extend to MAG_W and truncate back; the low bits of a
  // two's-complement negation do not depend on the upper bits.
  function automatic logic [MAG_W-1:0] cond_negate(input logic [MAG_W-1:0] value,
                                                   input logic             neg);
    return neg ? (~value + MAG_W'(1)) : value;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it does not borrow.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] acc;
  logic [WIDTH:0] diff;

  assign acc  = {rem_in, dvd_bit};
  assign diff = acc - {1'b0, divisor};

  // rem_in < divisor always holds, so acc < 2*divisor and the top bit of
  // the (WIDTH+1)-bit difference is exactly the borrow of the compare.
  assign q_bit   = ~diff[WIDTH];
  assign rem_out = q_bit ? diff[WIDTH-1:0] : acc[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider, one quotient bit per cycle.
// Define DIV_SIGNED_EN to honour is_signed (magnitudes, sign fix-up, MIN/-1).
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_e       state_reg, state_next;
  logic             accept;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] rem_reg, dvd_reg, dsr_reg;
  logic [WIDTH-1:0] quotient_reg, remainder_reg;
  logic             dbz_reg;
  logic [WIDTH-1:0] dvd_mag, dsr_mag, step_rem, q_raw, q_fix, r_fix;
  logic             step_q, zero_div, overflow, last_step;

  assign zero_div  = (divisor == '0);
  assign last_step = (count_reg == LAST);
  assign q_raw     = {dvd_reg[WIDTH-2:0], step_q};

`ifdef DIV_SIGNED_EN
  logic sign_a, sign_b, neg_q_reg, neg_r_reg;

  assign sign_a   = is_signed & dividend[WIDTH-1];
  assign sign_b   = is_signed & divisor[WIDTH-1];
  assign dvd_mag  = WIDTH'(cond_negate(MAG_W'(dividend), sign_a));
  assign dsr_mag  = WIDTH'(cond_negate(MAG_W'(divisor), sign_b));
  assign overflow = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor);
  assign q_fix    = WIDTH'(cond_negate(MAG_W'(q_raw), neg_q_reg));
  assign r_fix    = WIDTH'(cond_negate(MAG_W'(step_rem), neg_r_reg));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
    end else if (accept) begin
      neg_q_reg <= sign_a ^ sign_b;
      neg_r_reg <= sign_a;
    end
  end
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign dvd_mag  = dividend;
  assign dsr_mag  = divisor;
  assign overflow = 1'b0;
  assign q_fix    = q_raw;
  assign r_fix    = step_rem;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_reg),
    .dvd_bit (dvd_reg[WIDTH-1]),
    .divisor (dsr_reg),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush) begin
          accept     = 1'b1;
          state_next = (zero_div || overflow) ? DONE : CALC;
        end
      end
      CALC: if (last_step) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // The dividend register shifts left each step and fills with quotient bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg     <= '0;
      rem_reg       <= '0;
      dvd_reg       <= '0;
      dsr_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else if (accept) begin
      count_reg <= '0;
      rem_reg   <= '0;
      dvd_reg   <= dvd_mag;
      dsr_reg   <= dsr_mag;
      dbz_reg   <= zero_div;
      if (zero_div) begin
        quotient_reg  <= '1;
        remainder_reg <= dividend;
      end else if (overflow) begin
        quotient_reg  <= dividend;
        remainder_reg <= '0;
      end
    end else if (state_reg == CALC && !flush) begin
      count_reg <= count_reg + CW'(1);
      rem_reg   <= step_rem;
      dvd_reg   <= q_raw;
      if (last_step) begin
        quotient_reg  <= q_fix;
        remainder_reg <= r_fix;
      end
    end
  end

  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule
